// File: rtl/rd_req_arb_pkg.sv
// Shared constants for the RDMA read-request arbiter: burst-length field width,
// requester count, outstanding-command depth and the requester index names.
`timescale 1ns/1ps
package rd_req_arb_pkg;

  localparam int AXI_BURST_LEN      = 16;
  localparam int LOG2_AXI_BURST_LEN = $clog2(AXI_BURST_LEN);

  localparam int RDMA_NREQ      = 3;
  localparam int RDMA_ID_W      = 2;
  localparam int RDMA_OST_DEPTH = 8;
  localparam int RDMA_DAT_W     = 256;
  localparam int RDMA_PD_W      = LOG2_AXI_BURST_LEN + 64;

  typedef enum logic [RDMA_ID_W-1:0] {
    RDMA_ID_RES  = 2'd0,
    RDMA_ID_FEAT = 2'd1,
    RDMA_ID_WT   = 2'd2
  } rdma_id_e;

endpackage

// File: rtl/rd_req_arb_tag_fifo.sv
// Small synchronous FIFO holding {requester id, burst length} per outstanding
// command; the head is visible combinationally so responses route with no delay.
`timescale 1ns/1ps
module rd_tag_fifo #(
  parameter int  W     = 6,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rd_req_arb.sv
// Round-robin arbiter sharing one MCIF read channel among the RDMA engines; a tag
// FIFO remembers who issued each command so in-order response beats are routed back.
`timescale 1ns/1ps
module rd_req_arb
  import rd_req_arb_pkg::*;
#(
  parameter int  NREQ      = RDMA_NREQ,
  parameter int  ID_W      = RDMA_ID_W,
  parameter int  OST_DEPTH = RDMA_OST_DEPTH,
  parameter int  DAT_W     = RDMA_DAT_W,
  parameter int  LEN_W     = LOG2_AXI_BURST_LEN,
  parameter int  PD_W      = LEN_W + 64,
  localparam int CNT_W     = $clog2(OST_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*PD_W-1:0] req_pd,
  output logic                 rd_req_vld,
  input  logic                 rd_req_rdy,
  output logic [PD_W-1:0]      rd_req_pd,
  input  logic                 rd_rsp_vld,
  output logic                 rd_rsp_rdy,
  input  logic [DAT_W-1:0]     rd_rsp_pd,
  output logic [NREQ-1:0]      rsp_vld,
  input  logic [NREQ-1:0]      rsp_rdy,
  output logic [DAT_W-1:0]     rsp_pd,
  output logic                 rsp_last,
  output logic [CNT_W-1:0]     ost_cnt,
  output logic                 err
);

  localparam int TAG_W = ID_W + LEN_W;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic             err_q, err_d;

  logic             any_hi, any_lo, any_req, active_req;
  logic [ID_W-1:0]  id_hi, id_lo, grant_id;
  logic             tag_full, tag_empty;
  logic [TAG_W-1:0] push_tag, head_tag;
  logic [ID_W-1:0]  hid;
  logic [LEN_W-1:0] hlen;
  logic             hid_rdy;
  logic             cmd_hs, rsp_hs, rsp_pop;

  // Two passes: requesters at or above the pointer win first, then wrap to 0.
  always_comb begin
    any_hi = 1'b0;
    any_lo = 1'b0;
    id_hi  = '0;
    id_lo  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_hi && req_vld[i] && (ID_W'(i) >= ptr_q)) begin
        any_hi = 1'b1;
        id_hi  = ID_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any_lo && req_vld[i]) begin
        any_lo = 1'b1;
        id_lo  = ID_W'(i);
      end
    end
  end

  assign grant_id   = any_hi ? id_hi : id_lo;
  assign any_req    = any_hi | any_lo;
  // Request-side outputs are combinational from req_vld, so hold them low in reset.
  assign active_req = rst_n & any_req;

  assign rd_req_vld = active_req & ~tag_full;
  assign cmd_hs     = rd_req_vld & rd_req_rdy;

  always_comb begin
    rd_req_pd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (active_req && (grant_id == ID_W'(i))) rd_req_pd = req_pd[i*PD_W +: PD_W];
    end
  end

  assign push_tag = {grant_id, rd_req_pd[PD_W-1 -: LEN_W]};
  assign hid      = head_tag[TAG_W-1 -: ID_W];
  assign hlen     = head_tag[LEN_W-1:0];

  always_comb begin
    hid_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (hid == ID_W'(i)) hid_rdy = rsp_rdy[i];
    end
  end

  assign rd_rsp_rdy = ~tag_empty & hid_rdy;
  assign rsp_last   = ~tag_empty & (beat_q == hlen);
  assign rsp_hs     = rd_rsp_vld & rd_rsp_rdy;
  assign rsp_pop    = rsp_hs & rsp_last;
  assign rsp_pd     = rd_rsp_pd;
  assign err        = err_q;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_rdy[gi] = cmd_hs & (grant_id == ID_W'(gi));
    assign rsp_vld[gi] = rd_rsp_vld & ~tag_empty & (hid == ID_W'(gi));
  end

  rd_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (OST_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_hs),
    .pop_i   (rsp_pop),
    .wdata_i (push_tag),
    .rdata_o (head_tag),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (ost_cnt)
  );

  always_comb begin
    ptr_d  = ptr_q;
    beat_d = beat_q;
    err_d  = err_q | (rd_rsp_vld & tag_empty);
    if (cmd_hs) ptr_d = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
    if (rsp_pop)     beat_d = '0;
    else if (rsp_hs) beat_d = beat_q + LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      beat_q <= beat_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_rd_req_arb.sv
// Directed bench for rd_req_arb: a queue-based model is checked every cycle,
// and each scenario also pins a few hand-computed values.
`timescale 1ns/1ps
module tb_rd_req_arb;
  import rd_req_arb_pkg::*;

  localparam int NREQ  = 3;
  localparam int PD_W  = 68;
  localparam int DAT_W = 256;
  localparam int CNT_W = 4;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_vld = '0, req_rdy, rsp_vld, rsp_rdy = '1;
  logic [NREQ*PD_W-1:0] req_pd = '0;
  logic                 rd_req_vld, rd_req_rdy = 1'b1;
  logic [PD_W-1:0]      rd_req_pd;
  logic                 rd_rsp_vld = 1'b0, rd_rsp_rdy;
  logic [DAT_W-1:0]     rd_rsp_pd = '0, rsp_pd;
  logic                 rsp_last, err;
  logic [CNT_W-1:0]     ost_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: outstanding commands in issue order, pointer, beat index, error.
  int tag_id[$];
  int tag_len[$];
  int m_ptr = 0;
  int m_beat = 0;
  bit m_err = 1'b0;

  typedef struct {
    bit              rq_vld;
    logic [PD_W-1:0] rq_pd;
    logic [2:0]      rq_rdy;
    logic [2:0]      rs_vld;
    bit              rs_rdy;
    bit              last;
    int              ost;
    bit              err;
    int              gnt;
  } exp_t;

  int         lasts[$];
  logic [2:0] route_vld [3] = '{3'b100, 3'b100, 3'b001};
  logic [2:0] route_last[3] = '{3'b000, 3'b001, 3'b001};

  always #5 clk = ~clk;

  rd_req_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_pd     (req_pd),
    .rd_req_vld (rd_req_vld),
    .rd_req_rdy (rd_req_rdy),
    .rd_req_pd  (rd_req_pd),
    .rd_rsp_vld (rd_rsp_vld),
    .rd_rsp_rdy (rd_rsp_rdy),
    .rd_rsp_pd  (rd_rsp_pd),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_pd     (rsp_pd),
    .rsp_last   (rsp_last),
    .ost_cnt    (ost_cnt),
    .err        (err)
  );

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PD_W-1:0] mkpd(int len, int base);
    return {4'(len), 32'(base), 32'h0000_0040};
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   any;
    int   g;
    bit   full;
    bit   empty;
    e = '{default: 0};
    full  = (tag_id.size() >= DEPTH);
    empty = (tag_id.size() == 0);
    any = 1'b0;
    g   = 0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (!any && req_vld[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
    e.gnt = g;
    e.ost = tag_id.size();
    e.err = m_err;
    if (rst_n === 1'b1) begin
      e.rq_vld = any && !full;
      if (any) e.rq_pd = req_pd[g*PD_W +: PD_W];
      if (e.rq_vld && rd_req_rdy) e.rq_rdy[g] = 1'b1;
      if (!empty) begin
        e.rs_vld[tag_id[0]] = rd_rsp_vld;
        e.rs_rdy = rsp_rdy[tag_id[0]];
        e.last   = (m_beat == tag_len[0]);
      end
    end
    return e;
  endfunction

  // Model advance on the active edge (inputs are stable then) or async reset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      tag_id.delete();
      tag_len.delete();
      m_ptr  = 0;
      m_beat = 0;
      m_err  = 1'b0;
    end else begin
      exp_t e;
      bit   push;
      bit   hs;
      bit   pop;
      e    = model_out();
      push = e.rq_vld && rd_req_rdy;
      hs   = rd_rsp_vld && e.rs_rdy;
      pop  = hs && e.last;
      if (rd_rsp_vld && tag_id.size() == 0) m_err = 1'b1;
      if (hs) m_beat = pop ? 0 : m_beat + 1;
      if (pop) begin
        void'(tag_id.pop_front());
        void'(tag_len.pop_front());
      end
      if (push) begin
        tag_id.push_back(e.gnt);
        tag_len.push_back(int'(req_pd[e.gnt*PD_W + 64 +: 4]));
        m_ptr = (e.gnt + 1) % NREQ;
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    e = model_out();
    check("rd_req_vld", rd_req_vld, e.rq_vld);
    check("rd_req_pd",  rd_req_pd,  e.rq_pd);
    check("req_rdy",    req_rdy,    e.rq_rdy);
    check("rsp_vld",    rsp_vld,    e.rs_vld);
    check("rd_rsp_rdy", rd_rsp_rdy, e.rs_rdy);
    check("rsp_last",   rsp_last,   e.last);
    check("ost_cnt",    ost_cnt,    e.ost);
    check("err",        err,        e.err);
    check("rsp_pd",     rsp_pd,     rd_rsp_pd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_vld    = '0;
    req_pd     = '0;
    rd_req_rdy = 1'b1;
    rd_rsp_vld = 1'b0;
    rd_rsp_pd  = '0;
    rsp_rdy    = '1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic issue(int id, int len, int base);
    bit done;
    done = 1'b0;
    req_vld[id] = 1'b1;
    req_pd[id*PD_W +: PD_W] = mkpd(len, base);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (req_rdy[id]) done = 1'b1;
      tick();
    end
    req_vld[id] = 1'b0;
    check("issue_handshake", done, 1);
  endtask

  initial begin
    int hs;

    // Single requester, lengths 15 then 3: last beats are 16 and 20.
    do_reset();
    check("reset_ost", ost_cnt, 0);
    check("reset_err", err, 0);
    issue(RDMA_ID_RES, 15, 'h1000);
    issue(RDMA_ID_RES, 3, 'h2000);
    check("t1_ost_two", ost_cnt, 2);
    rd_rsp_vld = 1'b1;
    for (int b = 1; b <= 20; b++) begin
      rd_rsp_pd = DAT_W'(b) << 200 | DAT_W'(b);
      @(negedge clk);
      check("t1_rsp_vld", rsp_vld, 3'b001);
      if (rsp_last && rd_rsp_rdy) lasts.push_back(b);
      tick();
    end
    rd_rsp_vld = 1'b0;
    check("t1_nlast", lasts.size(), 2);
    check("t1_last0", lasts[0], 16);
    check("t1_last1", lasts[1], 20);
    check("t1_ost_end", ost_cnt, 0);

    // Fairness: all requesters held valid, grant rotates 0,1,2,0,1,2.
    do_reset();
    req_vld = 3'b111;
    for (int i = 0; i < NREQ; i++) req_pd[i*PD_W +: PD_W] = mkpd(0, 'h100 * (i + 1));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t2_grant", req_rdy, 3'b001 << (c % 3));
      tick();
    end
    req_vld = '0;

    // Full: eight commands fit, the ninth waits for the first pop.
    do_reset();
    rd_rsp_vld = 1'b0;
    req_vld[RDMA_ID_FEAT] = 1'b1;
    req_pd[1*PD_W +: PD_W] = mkpd(0, 'h3000);
    hs = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_rdy[1]) hs++;
      tick();
    end
    check("t3_accepted", hs, 8);
    check("t3_ost_full", ost_cnt, 8);
    check("t3_blocked", rd_req_vld, 0);
    rd_rsp_vld = 1'b1;
    @(negedge clk);
    check("t3_pop_rdy", rd_rsp_rdy, 1);
    check("t3_pop_last", rsp_last, 1);
    check("t3_pop_vld", rsp_vld, 3'b010);
    check("t3_still_blocked", rd_req_vld, 0);
    tick();
    rd_rsp_vld = 1'b0;
    @(negedge clk);
    check("t3_ninth_vld", rd_req_vld, 1);
    check("t3_ost_seven", ost_cnt, 7);
    tick();
    req_vld = '0;
    check("t3_ost_refill", ost_cnt, 8);

    // Routing: req 2 (two beats) then req 0 (one beat), with a 3-cycle stall.
    do_reset();
    issue(RDMA_ID_WT, 1, 'h4000);
    issue(RDMA_ID_RES, 0, 'h5000);
    rd_rsp_vld = 1'b1;
    rsp_rdy = 3'b011;
    for (int c = 0; c < 3; c++) begin
      rd_rsp_pd = DAT_W'(32'hAA + c);
      @(negedge clk);
      check("t4_stall_vld", rsp_vld, 3'b100);
      check("t4_stall_rdy", rd_rsp_rdy, 0);
      check("t4_stall_last", rsp_last, 0);
      tick();
    end
    rsp_rdy = 3'b111;
    for (int b = 0; b < 3; b++) begin
      rd_rsp_pd = DAT_W'(32'hB0 + b);
      @(negedge clk);
      check("t4_route_vld", rsp_vld, route_vld[b]);
      check("t4_route_last", rsp_last, route_last[b][0]);
      tick();
    end
    rd_rsp_vld = 1'b0;
    check("t4_ost_end", ost_cnt, 0);

    // Error: a response with nothing outstanding is refused and latches err.
    do_reset();
    rd_rsp_vld = 1'b1;
    @(negedge clk);
    check("t5_rdy_low", rd_rsp_rdy, 0);
    check("t5_err_before", err, 0);
    tick();
    rd_rsp_vld = 1'b0;
    @(negedge clk);
    check("t5_err_set", err, 1);
    repeat (3) tick();
    check("t5_err_sticky", err, 1);

    // Reset after 5 of 16 beats; afterwards the pointer must restart at 0.
    do_reset();
    issue(RDMA_ID_FEAT, 15, 'h6000);
    rd_rsp_vld = 1'b1;
    repeat (5) tick();
    check("t6_ost_mid", ost_cnt, 1);
    rst_n   = 1'b0;
    req_vld = 3'b110;
    req_pd[1*PD_W +: PD_W] = mkpd(2, 'h7000);
    req_pd[2*PD_W +: PD_W] = mkpd(2, 'h8000);
    #1;
    check("t6_rst_rd_req_vld", rd_req_vld, 0);
    check("t6_rst_req_rdy", req_rdy, 0);
    check("t6_rst_rsp_vld", rsp_vld, 0);
    check("t6_rst_rd_rsp_rdy", rd_rsp_rdy, 0);
    check("t6_rst_last", rsp_last, 0);
    check("t6_rst_ost", ost_cnt, 0);
    tick();
    rd_rsp_vld = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_grant_req1", req_rdy, 3'b010);
    tick();
    req_vld = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rd_req_arb.md
Name: rd_req_arb

Overview:
- Shares the single MCIF read-command channel and read-response channel between NREQ read-DMA engines: residual-add RDMA, feature RDMA and weight RDMA.
- Arbitrates read commands round-robin, one command per handshake.
- Records which requester issued each accepted command, then steers the returned data beats back to that requester in order.
- Sits between the per-layer RDMA engines and the MCIF.

Parameters:
- NREQ, 3, number of requesting RDMA engines; index 0 is highest priority after reset.
- ID_W, 2, requester index width; must satisfy 2^ID_W >= NREQ.
- OST_DEPTH, 8, maximum commands outstanding at the MCIF (depth of the tag FIFO).
- DAT_W, 256, MCIF response data width.
- PD_W, `log2AXI_BURST_LEN+64, command payload width: {length, base_addr, offset_addr}, with length in the top `log2AXI_BURST_LEN bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  NREQ  per-requester command valid.
- req_rdy  out  NREQ  per-requester command accept.
- req_pd  in  NREQ*PD_W  per-requester command payload; requester i occupies bits [i*PD_W +: PD_W].
- rd_req_vld  out  1  command valid to MCIF.
- rd_req_rdy  in  1  MCIF command accept.
- rd_req_pd  out  PD_W  selected command payload.
- rd_rsp_vld  in  1  MCIF response beat valid.
- rd_rsp_rdy  out  1  response beat accept to MCIF.
- rd_rsp_pd  in  DAT_W  response beat data.
- rsp_vld  out  NREQ  per-requester response valid.
- rsp_rdy  in  NREQ  per-requester response accept.
- rsp_pd  out  DAT_W  response data, shared by all requesters (rd_rsp_pd passed through).
- rsp_last  out  1  current beat is the last beat of its command.
- ost_cnt  out  log2(OST_DEPTH)+1  number of outstanding commands.
- err  out  1  sticky flag: response arrived with no outstanding command.

Behaviour:
- Reset (async, rst_n low): priority pointer = 0, tag FIFO empty, beat counter = 0, err = 0. All outputs reset to 0: rd_req_vld, req_rdy, rsp_vld, rd_rsp_rdy, rsp_last, ost_cnt = 0. Reset mid-operation discards all in-flight tags; the system must also reset the MCIF.
- Command arbitration is combinational, with zero-cycle latency from req_vld to rd_req_vld.
  - tag_full = (ost_cnt == OST_DEPTH).
  - grant = the first requester i with req_vld[i], searching from the pointer and wrapping modulo NREQ.
  - rd_req_vld = |req_vld & ~tag_full.
  - rd_req_pd = req_pd of the granted requester; 0 when no request is pending.
  - req_rdy[i] = grant[i] & rd_req_rdy & ~tag_full.
- Requesters hold vld and pd stable until they see rdy. The arbiter does not register the payload.
- On a command handshake (rd_req_vld & rd_req_rdy):
  - push {grant_id, length field} into the tag FIFO;
  - pointer <= grant_id+1, wrapping NREQ-1 back to 0.
  - The pointer does not move when there is no handshake.
- Response routing uses the head of the tag FIFO {hid, hlen}:
  - rsp_vld[i] = rd_rsp_vld & ~empty & (hid == i);
  - rd_rsp_rdy = ~empty & rsp_rdy[hid].
- beat_cnt increments on each response handshake.
  - rsp_last = ~empty & (beat_cnt == hlen).
  - On a handshake with rsp_last: beat_cnt <= 0 and the FIFO head pops. A length field of L therefore means L+1 beats.
- Simultaneous push and pop:
  - allowed when the FIFO is not full; ost_cnt is unchanged.
  - When full, push is blocked by tag_full even if a pop happens in the same cycle. This is one cycle of conservative backpressure and is intended.
- Empty FIFO with rd_rsp_vld = 1: rd_rsp_rdy = 0 and err <= 1, which holds until reset.
- ost_cnt is registered and increments or decrements on push and pop respectively.
- Response order equals command order (MCIF guarantees in-order return). Interleaving between requesters happens only at command boundaries.

Decomposition:
- CNN_defines.vh gains:
  - `RDMA_NREQ;
  - `RDMA_ID_W;
  - `RDMA_OST_DEPTH;
  - requester index constants `RDMA_ID_RES=0, `RDMA_ID_FEAT=1, `RDMA_ID_WT=2.
- One sub-module, rd_tag_fifo: a synchronous FIFO, width ID_W+`log2AXI_BURST_LEN, depth OST_DEPTH, with full, empty and count outputs. It is reused for ost_cnt.

Test Plan (`AXI_BURST_LEN=16, NREQ=3):
- Single requester: req 0 issues lengths 15 and 3, MCIF always ready → two commands pass through unchanged; 16 beats then 4 beats are returned on rsp_vld[0]; rsp_last is high on beats 16 and 20; ost_cnt ends at 0.
- Fairness: all three req_vld held high continuously, rd_req_rdy=1 → grant order is 0,1,2,0,1,2; each req_rdy is high exactly one cycle in three.
- Full: rd_rsp_vld=0, 9 commands requested → 8 are accepted; ost_cnt=8; rd_req_vld stays 0 until the first response beat with rsp_last is accepted, then the 9th command goes out in the following cycle.
- Routing and backpressure: commands issued in order 2(len 1), 0(len 0) → beats 1–2 go to requester 2 and beat 3 to requester 0. Holding rsp_rdy[2]=0 for 3 cycles stalls rd_rsp_rdy and does not advance beat_cnt.
- Error: rd_rsp_vld=1 pulsed with no outstanding command → rd_rsp_rdy=0 and err=1 from the next cycle, staying 1.
- Reset mid-burst: rst_n asserted after 5 of 16 beats → all outputs are 0 immediately and ost_cnt=0; after release, a fresh command to req 1 is granted first with the pointer starting at 0.
